// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: size encodings, FSM states, request
// payload and the access legality check.
package lsu_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DEF_MEM_BYTES = 44160;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ST0  = 3'd2,
        ST_ST1  = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    // Latched request payload.
    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // 1 when the access is misaligned, of illegal size, or runs past mem_bytes.
    // The end address is computed one bit wider so addresses near 2^32 cannot wrap.
    function automatic logic access_err(input logic [1:0]      size,
                                        input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] mem_bytes);
        logic [XLEN:0] end_addr;
        logic          bad;
        bad      = 1'b0;
        end_addr = '0;
        case (size)
            SZ_BYTE: end_addr = {1'b0, addr} + 33'd1;
            SZ_HALF: begin
                end_addr = {1'b0, addr} + 33'd2;
                bad      = addr[0];
            end
            SZ_WORD: begin
                end_addr = {1'b0, addr} + 33'd4;
                bad      = |addr[1:0];
            end
            default: bad = 1'b1;
        endcase
        return bad | (end_addr > {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension.
// Ports: word     - 32-bit word read from memory
//        addr_lo  - byte address bits [1:0]
//        size     - access size encoding
//        is_unsigned - 1 = zero-extend, 0 = sign-extend
//        data_c   - aligned, extended load result (combinational)
module load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to size and signedness.
    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = word[{addr_lo[1], 4'b0000} +: 16];
        data_c   = word;
        case (size)
            SZ_BYTE: data_c = is_unsigned ? {24'h0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data_c = is_unsigned ? {16'h0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            default: data_c = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and the memoria block.
// Ports: clock, reset (sync, active-high)
//        req_*   - request channel (valid/ready), size/sign/addr/store data
//        resp_*  - response channel (valid/ready), load data and error flag
//        mem_*   - memoria port set: dir, width, wen, in (to memory), out (from memory)
// Halfword stores are issued as two byte writes on consecutive cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_dir,
    output logic            mem_width,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_in,
    input  logic [XLEN-1:0] mem_out
);

    localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_BYTES);

    lsu_state_e      state_q, state_d;
    lsu_req_t        req_q, req_d;

    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            wen_q, wen_d;
    logic            width_q, width_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] dir_q, dir_d;
    logic [XLEN-1:0] in_q, in_d;
    logic [XLEN-1:0] load_data_c;

    load_align u_load_align (
        .word        (mem_out),
        .addr_lo     (req_q.addr[1:0]),
        .size        (req_q.size),
        .is_unsigned (req_q.uns),
        .data_c      (load_data_c)
    );

    // Next state, then every registered output derived from the next state so
    // the memory port reflects the state it belongs to.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    req_d = '{we: req_we, size: req_size, uns: req_unsigned,
                              addr: req_addr, wdata: req_wdata};
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (access_err(req_size, req_addr, MEM_LIMIT)) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d = ST_ST0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = load_data_c;
                state_d = ST_RESP;
            end
            ST_ST0: begin
                state_d = (req_q.size == SZ_HALF) ? ST_ST1 : ST_RESP;
            end
            ST_ST1: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
        wen_d   = (state_d == ST_ST0) || (state_d == ST_ST1);
        width_d = (state_d == ST_ST0) && (req_d.size == SZ_WORD);
        dir_d   = '0;
        in_d    = '0;
        case (state_d)
            ST_LOAD: dir_d = req_d.addr;
            ST_ST0: begin
                dir_d = req_d.addr;
                in_d  = (req_d.size == SZ_WORD) ? req_d.wdata : {24'h0, req_d.wdata[7:0]};
            end
            ST_ST1: begin
                dir_d = req_d.addr + 32'd1;
                in_d  = {24'h0, req_d.wdata[15:8]};
            end
            default: begin
                dir_d = '0;
                in_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wen_q   <= 1'b0;
            width_q <= 1'b0;
            dir_q   <= '0;
            in_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wen_q   <= wen_d;
            width_q <= width_d;
            dir_q   <= dir_d;
            in_q    <= in_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign mem_dir    = dir_q;
    assign mem_width  = width_q;
    assign mem_in     = in_q;
    // Reset must suppress a write already scheduled for this edge (e.g. in ST1).
    assign mem_wen    = wen_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned MEMB  = 44160;
    localparam int unsigned WORDS = MEMB / 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_dir, mem_in, mem_out;
    logic        mem_width, mem_wen;

    int n_tests = 0;
    int n_fail  = 0;

    // memoria: word array with combinational read and byte/word write
    logic [31:0] mem [0:WORDS-1];
    int          wr_cnt = 0;
    logic [31:0] wr_dir_q [$];
    logic [7:0]  wr_byte_q [$];

    // reference model storage: flat byte array
    logic [7:0]  ref_mem [0:MEMB-1];

    always #5 clock = ~clock;

    load_store_unit #(.MEM_BYTES(MEMB)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_dir      (mem_dir),
        .mem_width    (mem_width),
        .mem_wen      (mem_wen),
        .mem_in       (mem_in),
        .mem_out      (mem_out)
    );

    assign mem_out = (mem_dir[31:2] < 30'(WORDS)) ? mem[mem_dir[15:2]] : 32'h0;

    always @(posedge clock) begin
        if (mem_wen) begin
            if (mem_dir[31:2] < 30'(WORDS)) begin
                if (mem_width) mem[mem_dir[15:2]] = mem_in;
                else           mem[mem_dir[15:2]][{mem_dir[1:0], 3'b000} +: 8] = mem_in[7:0];
            end
            wr_cnt = wr_cnt + 1;
            wr_dir_q.push_back(mem_dir);
            wr_byte_q.push_back(mem_in[7:0]);
        end
    end

    // Behavioural model: legality, latency, write count and load value from byte array.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] exp_rd, output logic exp_err,
                                  output int exp_lat, output int exp_wr);
        logic [63:0] a64, v;
        int nb;
        a64 = 64'(addr);
        exp_rd = '0; exp_wr = 0; exp_lat = 1; nb = 0;
        if (size == 2'b11) exp_err = 1'b1;
        else begin
            nb = 1 << size;
            exp_err = ((a64 % 64'(nb)) != 0) || ((a64 + 64'(nb)) > 64'(MEMB));
        end
        if (exp_err) return;
        exp_lat = 2;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a64) + i] = wdata[8*i +: 8];
            exp_wr = (nb == 2) ? 2 : 1;
            if (nb == 2) exp_lat = 3;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[int'(a64) + i]) << (8*i));
            if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
            exp_rd = v[31:0];
        end
    endfunction

    // Drive one request, measure latency to resp_valid, hold resp_ready low for 'stall' cycles.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                          output logic [31:0] rd, output logic er, output int lat, output int nwr,
                          output logic [31:0] exp_rd, output logic exp_er,
                          output int exp_lat, output int exp_wr);
        int n, base;
        model(we, size, uns, addr, wdata, exp_rd, exp_er, exp_lat, exp_wr);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        resp_ready = 1'b0;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        base = wr_cnt;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 50) begin @(negedge clock); lat++; end
        rd = resp_rdata;
        er = resp_err;
        repeat (stall) @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        nwr = wr_cnt - base;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({req_ready, resp_valid, resp_err, mem_wen, mem_width} !== 5'b0 ||
            resp_rdata !== 32'h0 || mem_dir !== 32'h0 || mem_in !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b err=%b wen=%b width=%b rdata=%h dir=%h in=%h, required all 0",
                     req_ready, resp_valid, resp_err, mem_wen, mem_width, resp_rdata, mem_dir, mem_in);
        end
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic er, eer; int lat, elat, nwr, ewr;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (mem[2] !== 32'hDEADBEEF || er !== 1'b0 || lat != 2 || nwr != 1) begin
            n_fail++; $display("FAIL word_store: mem=%h err=%b lat=%0d writes=%0d, required DEADBEEF 0 2 1", mem[2], er, lat, nwr);
        end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2 || nwr != 0) begin
            n_fail++; $display("FAIL word_load: rdata=%h err=%b lat=%0d writes=%0d, required DEADBEEF 0 2 0", rd, er, lat, nwr);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd; logic er, eer; int lat, elat, nwr, ewr;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h0, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h12345688, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (mem[2] !== 32'h00008800 || rd !== 32'h0 || lat != 2 || nwr != 1) begin
            n_fail++; $display("FAIL byte_store: mem=%h rdata=%h lat=%0d writes=%0d, required 00008800 0 2 1", mem[2], rd, lat, nwr);
        end
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (rd !== 32'hFFFFFF88 || er !== 1'b0) begin
            n_fail++; $display("FAIL byte_load_signed: rdata=%h err=%b, required FFFFFF88 0", rd, er);
        end
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (rd !== 32'h00000088 || er !== 1'b0) begin
            n_fail++; $display("FAIL byte_load_unsigned: rdata=%h err=%b, required 00000088 0", rd, er);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd, erd; logic er, eer; int lat, elat, nwr, ewr, qs;
        qs = wr_dir_q.size();
        do_req(1'b1, SZ_HALF, 1'b0, 32'h6, 32'h0000A55A, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (wr_dir_q.size() != qs + 2) begin
            n_fail++; $display("FAIL half_store_writes: got %0d writes, required 2", wr_dir_q.size() - qs);
        end else if ({wr_dir_q[qs], wr_byte_q[qs], wr_dir_q[qs+1], wr_byte_q[qs+1]} !==
                     {32'h6, 8'h5A, 32'h7, 8'hA5}) begin
            n_fail++; $display("FAIL half_store_writes: got %h/%h then %h/%h, required 6/5a then 7/a5",
                               wr_dir_q[qs], wr_byte_q[qs], wr_dir_q[qs+1], wr_byte_q[qs+1]);
        end
        n_tests++;
        if (mem[1] !== 32'hA55A0000 || lat != 3) begin
            n_fail++; $display("FAIL half_store_word: mem=%h lat=%0d, required A55A0000 3", mem[1], lat);
        end
        do_req(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (rd !== 32'hFFFFA55A || er !== 1'b0 || lat != 2) begin
            n_fail++; $display("FAIL half_load_signed: rdata=%h err=%b lat=%0d, required FFFFA55A 0 2", rd, er, lat);
        end
    endtask

    task automatic test_errors();
        logic        t_we [4];
        logic [1:0]  t_sz [4];
        logic [31:0] t_ad [4];
        logic [31:0] rd, erd; logic er, eer; int lat, elat, nwr, ewr;
        t_we = '{1'b0, 1'b1, 1'b0, 1'b0};
        t_sz = '{SZ_WORD, SZ_HALF, SZ_ILL, SZ_WORD};
        t_ad = '{32'h2, 32'h5, 32'h0, 32'(MEMB)};
        for (int i = 0; i < 4; i++) begin
            do_req(t_we[i], t_sz[i], 1'b0, t_ad[i], 32'hFFFFFFFF, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
            n_tests++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || nwr != 0) begin
                n_fail++; $display("FAIL error_case%0d: err=%b rdata=%h lat=%0d writes=%0d, required 1 0 1 0", i, er, rd, lat, nwr);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd, erd; logic er, eer; int lat, elat, nwr, ewr;
        do_req(1'b0, SZ_WORD, 1'b0, 32'(MEMB - 4), 32'h0, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (er !== 1'b0 || rd !== 32'h0 || lat != 2) begin
            n_fail++; $display("FAIL last_word_load: err=%b rdata=%h lat=%0d, required 0 0 2", er, rd, lat);
        end
        do_req(1'b0, SZ_HALF, 1'b0, 32'(MEMB - 1), 32'h0, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (er !== 1'b1 || lat != 1) begin
            n_fail++; $display("FAIL last_byte_half: err=%b lat=%0d, required 1 1", er, lat);
        end
        do_req(1'b1, SZ_BYTE, 1'b0, 32'(MEMB - 1), 32'h0000005C, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        n_tests++;
        if (er !== 1'b0 || nwr != 1 || mem[WORDS-1] !== 32'h5C000000) begin
            n_fail++; $display("FAIL last_byte_store: err=%b writes=%0d mem=%h, required 0 1 5C000000", er, nwr, mem[WORDS-1]);
        end
    endtask

    task automatic test_resp_stall();
        logic [31:0] rd, erd; logic er, eer; int lat, elat, nwr, ewr, base, n;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678, 0, rd, er, lat, nwr, erd, eer, elat, ewr);
        req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
        resp_ready = 1'b0;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 10) begin @(negedge clock); n++; end
        base = wr_cnt;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({resp_valid, resp_err, req_ready, mem_wen, resp_rdata} !== {4'b1000, 32'h12345678}) begin
                n_fail++; $display("FAIL stall_cycle%0d: valid=%b err=%b ready=%b wen=%b rdata=%h, required 1 0 0 0 12345678",
                                   c, resp_valid, resp_err, req_ready, mem_wen, resp_rdata);
            end
            @(negedge clock);
        end
        n_tests++;
        if (wr_cnt != base) begin
            n_fail++; $display("FAIL stall_writes: got %0d writes, required 0", wr_cnt - base);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_st1();
        int base;
        base = wr_cnt;
        req_we = 1'b1; req_size = SZ_HALF; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h00001234;
        resp_ready = 1'b0;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({mem_wen, mem_width, mem_dir, mem_in} !== {2'b10, 32'h11, 32'h12}) begin
            n_fail++; $display("FAIL st1_port: wen=%b width=%b dir=%h in=%h, required 1 0 00000011 00000012",
                               mem_wen, mem_width, mem_dir, mem_in);
        end
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({req_ready, resp_valid, resp_err, mem_wen, mem_width} !== 5'b0 ||
            resp_rdata !== 32'h0 || mem_dir !== 32'h0 || mem_in !== 32'h0) begin
            n_fail++; $display("FAIL midreset_outputs: ready=%b valid=%b err=%b wen=%b width=%b rdata=%h dir=%h in=%h, required all 0",
                               req_ready, resp_valid, resp_err, mem_wen, mem_width, resp_rdata, mem_dir, mem_in);
        end
        n_tests++;
        if (mem[4] !== 32'h00000034 || wr_cnt - base != 1) begin
            n_fail++; $display("FAIL midreset_mem: mem=%h writes=%0d, required 00000034 1", mem[4], wr_cnt - base);
        end
        ref_mem[16] = 8'h34;
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_random();
        logic        we, uns, er, eer;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rd, erd, ref_word;
        int          lat, elat, nwr, ewr, b;
        for (int t = 0; t < 200; t++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 15) == 0) ? SZ_ILL : 2'($urandom_range(0, 2));
            addr  = ($urandom_range(0, 7) == 0) ? 32'(MEMB - 8 + $urandom_range(0, 11))
                                                : 32'($urandom_range(0, 63));
            wdata = $urandom;
            do_req(we, size, uns, addr, wdata, int'($urandom_range(0, 2)),
                   rd, er, lat, nwr, erd, eer, elat, ewr);
            n_tests++;
            if ({er, rd} !== {eer, erd}) begin
                n_fail++; $display("FAIL rand_resp t=%0d we=%b sz=%0d u=%b a=%h: err=%b rdata=%h, required %b %h",
                                   t, we, size, uns, addr, er, rd, eer, erd);
            end
            n_tests++;
            if (lat != elat || nwr != ewr) begin
                n_fail++; $display("FAIL rand_timing t=%0d: lat=%0d writes=%0d, required %0d %0d", t, lat, nwr, elat, ewr);
            end
            if (we && !eer) begin
                b = int'({addr[31:2], 2'b00});
                ref_word = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
                n_tests++;
                if (mem[addr[15:2]] !== ref_word) begin
                    n_fail++; $display("FAIL rand_mem t=%0d a=%h: got %h required %h", t, addr, mem[addr[15:2]], ref_word);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'h0;
        for (int i = 0; i < int'(MEMB); i++) ref_mem[i] = 8'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_boundary();
        test_resp_stall();
        test_reset_mid_st1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
